// File: rtl/interlaken_latency_probe.sv
`default_nettype none
// ============================================================================
// Module   : interlaken_latency_probe
// Brief    : N-channel trigger-to-reply round-trip latency probe on LBUS.
// Revision : 1.0 - initial release
// ============================================================================
module interlaken_latency_probe #(
    parameter int              NUM_CH  = 9,
    parameter int              CH_W    = 4,
    parameter int              SEQ_W   = 8,
    parameter int              TS_W    = 32,
    parameter longint unsigned TIMEOUT = 65535
) (
    input  logic              lbus_clk,
    input  logic              clk_reset,
    input  logic [NUM_CH-1:0] send_msg,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CH_W-1:0]   tx_ch,
    output logic [SEQ_W-1:0]  tx_seq,
    output logic [TS_W-1:0]   tx_ts,
    input  logic              rx_valid,
    input  logic [CH_W-1:0]   rx_ch,
    input  logic [SEQ_W-1:0]  rx_seq,
    output logic              lat_valid,
    output logic [CH_W-1:0]   lat_ch,
    output logic [TS_W-1:0]   lat_cycles,
    output logic              lat_timeout,
    output logic [NUM_CH-1:0] busy,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_ARMED  = 2'd1;
    localparam logic [1:0]      ST_PEND   = 2'd2;
    localparam logic [TS_W-1:0] C_TIMEOUT = TS_W'(TIMEOUT);
    localparam logic [CH_W-1:0] C_LAST    = CH_W'(NUM_CH - 1);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [NUM_CH-1:0] send_q;
    logic [1:0]        st_q     [NUM_CH];
    logic [1:0]        st_d     [NUM_CH];
    logic [SEQ_W-1:0]  seq_q    [NUM_CH];
    logic [SEQ_W-1:0]  seq_d    [NUM_CH];
    logic [SEQ_W-1:0]  lseq_q   [NUM_CH];
    logic [SEQ_W-1:0]  lseq_d   [NUM_CH];
    logic [TS_W-1:0]   launch_q [NUM_CH];
    logic [TS_W-1:0]   launch_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              tx_valid_q, tx_valid_d;
    logic [CH_W-1:0]   tx_ch_q, tx_ch_d;
    logic [SEQ_W-1:0]  tx_seq_q, tx_seq_d;
    logic              lat_valid_q, lat_valid_d;
    logic [CH_W-1:0]   lat_ch_q, lat_ch_d;
    logic [TS_W-1:0]   lat_cycles_q, lat_cycles_d;
    logic              lat_timeout_q, lat_timeout_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       err_q, err_d;

    logic              hs;
    logic              hold;
    logic              match;
    logic              found_to;
    logic              found_tx;
    logic              any_drop;
    logic [TS_W-1:0]   match_lat;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] timed_out;
    logic [NUM_CH-1:0] retire;

    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        st_d          = st_q;
        seq_d         = seq_q;
        lseq_d        = lseq_q;
        launch_d      = launch_q;
        ptr_d         = ptr_q;
        tx_valid_d    = tx_valid_q;
        tx_ch_d       = tx_ch_q;
        tx_seq_d      = tx_seq_q;
        lat_valid_d   = 1'b0;
        lat_ch_d      = '0;
        lat_cycles_d  = '0;
        lat_timeout_d = 1'b0;
        drop_d        = drop_q;
        err_d         = err_q;
        hs            = tx_valid_q & tx_ready;
        hold          = tx_valid_q & ~tx_ready;
        rise          = send_msg & ~send_q;
        match         = 1'b0;
        match_lat     = '0;
        found_to      = 1'b0;
        found_tx      = 1'b0;
        any_drop      = 1'b0;
        elig          = '0;
        timed_out     = '0;
        retire        = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            elig[i]      = (st_q[i] == ST_ARMED) && !(hs && tx_ch_q == CH_W'(i));
            timed_out[i] = (st_q[i] == ST_PEND) && ((ts_q - launch_q[i]) >= C_TIMEOUT);
            if (rx_valid && rx_ch == CH_W'(i) && st_q[i] == ST_PEND && rx_seq == lseq_q[i]) begin
                match     = 1'b1;
                match_lat = ts_q - launch_q[i];
                retire[i] = 1'b1;
            end
        end

        // A returned tag beats every timeout; among timeouts the lowest channel wins.
        if (match) begin
            lat_valid_d  = 1'b1;
            lat_ch_d     = rx_ch;
            lat_cycles_d = match_lat;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found_to && timed_out[i]) begin
                    found_to      = 1'b1;
                    retire[i]     = 1'b1;
                    lat_valid_d   = 1'b1;
                    lat_ch_d      = CH_W'(i);
                    lat_cycles_d  = C_TIMEOUT;
                    lat_timeout_d = 1'b1;
                end
            end
        end

        if (rx_valid && !match && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (rise[i]) begin
                if (st_q[i] == ST_IDLE) begin
                    st_d[i] = ST_ARMED;
                end else begin
                    any_drop = 1'b1;
                end
            end
            if (retire[i]) begin
                st_d[i] = ST_IDLE;
            end
            if (hs && tx_ch_q == CH_W'(i)) begin
                st_d[i]     = ST_PEND;
                launch_d[i] = ts_q;
                lseq_d[i]   = seq_q[i];
                seq_d[i]    = seq_q[i] + SEQ_W'(1);
            end
        end

        if (any_drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end

        if (hs) begin
            ptr_d = (tx_ch_q == C_LAST) ? '0 : tx_ch_q + CH_W'(1);
        end

        // Round-robin: first scan from the pointer upward, then wrap to the bottom.
        if (!hold) begin
            tx_valid_d = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found_tx && elig[i] && CH_W'(i) >= ptr_d) begin
                    found_tx   = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_ch_d    = CH_W'(i);
                    tx_seq_d   = seq_q[i];
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found_tx && elig[i]) begin
                    found_tx   = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_ch_d    = CH_W'(i);
                    tx_seq_d   = seq_q[i];
                end
            end
        end
    end

    always_ff @(posedge lbus_clk) begin
        if (clk_reset) begin
            ts_q          <= '0;
            send_q        <= '0;
            ptr_q         <= '0;
            tx_valid_q    <= 1'b0;
            tx_ch_q       <= '0;
            tx_seq_q      <= '0;
            lat_valid_q   <= 1'b0;
            lat_ch_q      <= '0;
            lat_cycles_q  <= '0;
            lat_timeout_q <= 1'b0;
            drop_q        <= '0;
            err_q         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]     <= ST_IDLE;
                seq_q[i]    <= '0;
                lseq_q[i]   <= '0;
                launch_q[i] <= '0;
            end
        end else begin
            ts_q          <= ts_d;
            send_q        <= send_msg;
            ptr_q         <= ptr_d;
            tx_valid_q    <= tx_valid_d;
            tx_ch_q       <= tx_ch_d;
            tx_seq_q      <= tx_seq_d;
            lat_valid_q   <= lat_valid_d;
            lat_ch_q      <= lat_ch_d;
            lat_cycles_q  <= lat_cycles_d;
            lat_timeout_q <= lat_timeout_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            st_q          <= st_d;
            seq_q         <= seq_d;
            lseq_q        <= lseq_d;
            launch_q      <= launch_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
            assign busy[g] = (st_q[g] != ST_IDLE);
        end
    endgenerate

    assign tx_valid    = tx_valid_q;
    assign tx_ch       = tx_ch_q;
    assign tx_seq      = tx_seq_q;
    assign tx_ts       = ts_q;
    assign lat_valid   = lat_valid_q;
    assign lat_ch      = lat_ch_q;
    assign lat_cycles  = lat_cycles_q;
    assign lat_timeout = lat_timeout_q;
    assign drop_cnt    = drop_q;
    assign err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_interlaken_latency_probe.sv
`default_nettype none
// ============================================================================
// Module   : tb_interlaken_latency_probe
// Brief    : Directed and random checks of interlaken_latency_probe vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interlaken_latency_probe;

    localparam int NCH = 9;
    localparam int CW  = 4;
    localparam int SW  = 8;
    localparam int TW  = 10;
    localparam int TO  = 50;
    localparam int TSM = 1 << TW;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] send;
    logic           ready;
    logic           rxv;
    logic [CW-1:0]  rxch;
    logic [SW-1:0]  rxseq;
    logic           tx_valid, lat_valid, lat_timeout;
    logic [CW-1:0]  tx_ch, lat_ch;
    logic [SW-1:0]  tx_seq;
    logic [TW-1:0]  tx_ts, lat_cycles;
    logic [NCH-1:0] busy;
    logic [15:0]    drop_cnt, err_cnt;

    interlaken_latency_probe #(
        .NUM_CH (NCH),
        .CH_W   (CW),
        .SEQ_W  (SW),
        .TS_W   (TW),
        .TIMEOUT(TO)
    ) dut (
        .lbus_clk   (clk),
        .clk_reset  (rst),
        .send_msg   (send),
        .tx_valid   (tx_valid),
        .tx_ready   (ready),
        .tx_ch      (tx_ch),
        .tx_seq     (tx_seq),
        .tx_ts      (tx_ts),
        .rx_valid   (rxv),
        .rx_ch      (rxch),
        .rx_seq     (rxseq),
        .lat_valid  (lat_valid),
        .lat_ch     (lat_ch),
        .lat_cycles (lat_cycles),
        .lat_timeout(lat_timeout),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: channel status 0=idle 1=armed 2=awaiting reply.
    int             m_ts, m_ptr, m_txch, m_txseq, m_latch, m_latcyc, m_drop, m_err;
    bit             m_txv, m_latv, m_latto;
    int             m_st     [NCH];
    int             m_seq    [NCH];
    int             m_lseq   [NCH];
    int             m_launch [NCH];
    bit [NCH-1:0]   m_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int age(input int c);
        return (m_ts - m_launch[c] + TSM) % TSM;
    endfunction

    task automatic model_tick();
        int old [NCH];
        bit hs, match, drop, held;
        int hc, rc, c;
        if (rst) begin
            m_ts = 0; m_ptr = 0; m_txch = 0; m_txseq = 0; m_txv = 0;
            m_latv = 0; m_latch = 0; m_latcyc = 0; m_latto = 0;
            m_drop = 0; m_err = 0; m_prev = '0;
            for (int i = 0; i < NCH; i++) begin
                m_st[i] = 0; m_seq[i] = 0; m_lseq[i] = 0; m_launch[i] = 0;
            end
            return;
        end
        old   = m_st;
        hs    = m_txv && ready;
        hc    = m_txch;
        rc    = int'(rxch);
        match = 0;
        if (rxv && rc < NCH) begin
            if (old[rc] == 2 && m_lseq[rc] == int'(rxseq)) match = 1;
        end
        m_latv = 0; m_latto = 0; m_latch = 0; m_latcyc = 0;
        if (match) begin
            m_latv = 1; m_latch = rc; m_latcyc = age(rc); m_st[rc] = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!m_latv && old[i] == 2 && age(i) >= TO) begin
                    m_latv = 1; m_latto = 1; m_latch = i; m_latcyc = TO; m_st[i] = 0;
                end
            end
        end
        if (rxv && !match && m_err < 65535) m_err++;
        drop = 0;
        for (int i = 0; i < NCH; i++) begin
            if (send[i] && !m_prev[i]) begin
                if (old[i] == 0) m_st[i] = 1;
                else drop = 1;
            end
        end
        if (drop && m_drop < 65535) m_drop++;
        held = m_txv && !ready;
        if (hs) begin
            m_st[hc] = 2; m_launch[hc] = m_ts; m_lseq[hc] = m_seq[hc];
            m_seq[hc] = (m_seq[hc] + 1) % (1 << SW);
            m_ptr = (hc + 1) % NCH;
        end
        if (!held) begin
            m_txv = 0;
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (!m_txv && old[c] == 1 && !(hs && c == hc)) begin
                    m_txv = 1; m_txch = c; m_txseq = m_seq[c];
                end
            end
        end
        m_prev = send;
        m_ts   = (m_ts + 1) % TSM;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = (m_st[i] != 0);
        chk("tx_valid", tx_valid, m_txv);
        if (m_txv) begin
            chk("tx_ch", tx_ch, m_txch);
            chk("tx_seq", tx_seq, m_txseq);
        end
        chk("tx_ts", tx_ts, m_ts);
        chk("lat_valid", lat_valid, m_latv);
        if (m_latv) begin
            chk("lat_ch", lat_ch, m_latch);
            chk("lat_cycles", lat_cycles, m_latcyc);
            chk("lat_timeout", lat_timeout, m_latto);
        end
        chk("busy", busy, b);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_cnt", err_cnt, m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_txv"}, tx_valid, 0);
        chk({tag, "_txch"}, tx_ch, 0);
        chk({tag, "_txseq"}, tx_seq, 0);
        chk({tag, "_txts"}, tx_ts, 0);
        chk({tag, "_latv"}, lat_valid, 0);
        chk({tag, "_latch"}, lat_ch, 0);
        chk({tag, "_latcyc"}, lat_cycles, 0);
        chk({tag, "_latto"}, lat_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1; send = '0; ready = 0; rxv = 0; rxch = '0; rxseq = '0;
        repeat (3) cyc();
        rst = 0;
    endtask

    task automatic wait_ts(input int t);
        int n = 0;
        while (m_ts != t && n < 2000) begin cyc(); n++; end
        chk("wait_ts_bound", m_ts, t);
    endtask

    task automatic wait_pending(input int c);
        int n = 0;
        while (m_st[c] != 2 && n < 40) begin cyc(); n++; end
        chk("wait_pending_bound", busy[c], 1);
    endtask

    task automatic rx_pulse(input int c, input int s);
        rxv = 1; rxch = CW'(c); rxseq = SW'(s);
        cyc();
        rxv = 0;
    endtask

    initial begin
        int L, n, r, c;
        int q[$];

        // Reset state and a single round trip of 40 cycles.
        do_reset();
        check_zero("reset");
        wait_ts(98);
        send[3] = 1; ready = 1;
        cyc();
        send = '0;
        wait_pending(3);
        L = m_launch[3];
        wait_ts((L + 40) % TSM);
        rx_pulse(3, 0);
        chk("rt_valid", lat_valid, 1);
        chk("rt_ch", lat_ch, 3);
        chk("rt_cycles", lat_cycles, 40);
        chk("rt_timeout", lat_timeout, 0);
        chk("rt_busy3", busy[3], 0);

        // Stalled offer holds, then round-robin order 0,4,8.
        do_reset();
        send = 9'b1_0001_0001;
        cyc();
        n = 0;
        while (!tx_valid && n < 10) begin cyc(); n++; end
        repeat (5) begin
            chk("stall_ch", tx_ch, 0);
            chk("stall_seq", tx_seq, 0);
            cyc();
        end
        ready = 1;
        for (int k = 0; k < 10; k++) begin
            if (tx_valid && ready) q.push_back(int'(tx_ch));
            cyc();
        end
        chk("rr_count", q.size(), 3);
        chk("rr_first", q.size() > 0 ? q[0] : 99, 0);
        chk("rr_second", q.size() > 1 ? q[1] : 99, 4);
        chk("rr_third", q.size() > 2 ? q[2] : 99, 8);
        send = '0;

        // Drops while pending and a wrong-sequence reply.
        do_reset();
        ready = 1; send[2] = 1;
        cyc();
        send = '0;
        wait_pending(2);
        send[2] = 1; cyc(); send = '0; cyc();
        send[2] = 1; cyc(); send = '0; cyc();
        chk("drop_two", drop_cnt, 2);
        rx_pulse(2, 1);
        chk("bad_seq_err", err_cnt, 1);
        chk("bad_seq_busy", busy[2], 1);

        // Timeout, then a late reply.
        do_reset();
        ready = 1; send[1] = 1;
        cyc();
        send = '0;
        wait_pending(1);
        L = m_launch[1];
        n = 0;
        while (!lat_valid && n < 80) begin cyc(); n++; end
        chk("to_ch", lat_ch, 1);
        chk("to_flag", lat_timeout, 1);
        chk("to_cycles", lat_cycles, TO);
        chk("to_when", tx_ts, (L + TO + 1) % TSM);
        repeat (4) cyc();
        rx_pulse(1, 0);
        chk("late_err", err_cnt, 1);

        // Latency across timestamp wrap.
        do_reset();
        ready = 1;
        wait_ts(TSM - 18);
        send[0] = 1;
        cyc();
        send = '0;
        wait_pending(0);
        L = m_launch[0];
        wait_ts((L + 32) % TSM);
        rx_pulse(0, 0);
        chk("wrap_valid", lat_valid, 1);
        chk("wrap_cycles", lat_cycles, 32);

        // Match beats simultaneous timeouts; timeouts retire lowest first.
        do_reset();
        ready = 1; send = 9'b0_0110_0010;
        cyc();
        send = '0;
        wait_pending(6);
        L = m_launch[1];
        wait_ts((L + TO) % TSM);
        rx_pulse(6, 0);
        chk("prio0_ch", lat_ch, 6);
        chk("prio0_to", lat_timeout, 0);
        cyc();
        chk("prio1_ch", lat_ch, 1);
        chk("prio1_to", lat_timeout, 1);
        cyc();
        chk("prio2_ch", lat_ch, 5);
        chk("prio2_to", lat_timeout, 1);

        // Reset with a probe outstanding; its reply becomes an error.
        send[1] = 1;
        cyc();
        send = '0;
        wait_pending(1);
        rst = 1;
        cyc();
        check_zero("mid_reset");
        rst = 0;
        rx_pulse(1, 1);
        chk("discard_err", err_cnt, 1);

        // Random traffic against the model.
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(5) == 0) send[i] = ~send[i];
            end
            ready = ($urandom_range(3) != 0);
            r = $urandom_range(9);
            c = $urandom_range(NCH - 1);
            rxv = 0;
            if (r < 4 && m_st[c] == 2) begin
                rxv = 1; rxch = CW'(c); rxseq = SW'(m_lseq[c]);
            end else if (r == 4) begin
                rxv = 1; rxch = CW'($urandom_range(15)); rxseq = SW'($urandom_range(255));
            end
            rst = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 0; rxv = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
